// File: rtl/imem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_arb_pkg
// Purpose  : Shared types and defaults for the instruction-memory read arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package imem_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  // Sequencing states of one shared memory access
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Requester identifier: 0 = instruction fetch, 1 = debug/loader
  typedef logic port_id_t;

endpackage : imem_arb_pkg
`default_nettype wire

// File: rtl/imem_read_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Combinational two-way round-robin pick. A lone requester always
//            wins; when both request, the port not granted last time wins.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
  import imem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  port_id_t   last_grant_i,
  output port_id_t   grant_o,
  output logic       valid_o
);

  // Pick winner from the current request vector and the previous grant
  always_comb begin
    valid_o = |req_i;
    grant_o = 1'b0;
    if (req_i == 2'b11) begin
      grant_o = ~last_grant_i;
    end else if (req_i[1]) begin
      grant_o = 1'b1;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/imem_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_read_arbiter
// Purpose  : Shares one memory_hierarchy read port between instruction fetch
//            (port 0) and debug/loader read-back (port 1). Each access holds
//            read_enable/address until rd_ready, returns data with a one-cycle
//            ack, or aborts with a one-cycle error when the watchdog expires.
// Revision : 1.0 - initial release
// ============================================================================
module imem_read_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rq0_req,
  input  logic [ADDR_W-1:0] rq0_addr,
  output logic              rq0_ack,
  output logic              rq0_err,
  output logic [DATA_W-1:0] rq0_data,
  input  logic              rq1_req,
  input  logic [ADDR_W-1:0] rq1_addr,
  output logic              rq1_ack,
  output logic              rq1_err,
  output logic [DATA_W-1:0] rq1_data,
  output logic              mem_read_enable,
  output logic [ADDR_W-1:0] mem_address,
  input  logic              mem_rd_ready,
  input  logic [DATA_W-1:0] mem_inst
);

  // A zero TIMEOUT disables the watchdog; keep the counter one bit wide then
  localparam int WD_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [WD_W-1:0] WD_MAX  = {WD_W{1'b1}};
  localparam logic [WD_W-1:0] TO_LAST = TO_LAST_I[WD_W-1:0];

  state_t              state_q, state_d;
  port_id_t            id_q, id_d;
  port_id_t            last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                re_q, re_d;
  logic [DATA_W-1:0]   data0_q, data0_d, data1_q, data1_d;
  logic                ack0_q, ack0_d, ack1_q, ack1_d;
  logic                err0_q, err0_d, err1_q, err1_d;

  port_id_t            arb_grant;
  logic                arb_valid;

  rr_arb2 u_arb (
    .req_i        ({rq1_req, rq0_req}),
    .last_grant_i (last_q),
    .grant_o      (arb_grant),
    .valid_o      (arb_valid)
  );

  // Next-state and registered-output computation for the access sequencer
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    re_d    = 1'b0;
    data0_d = data0_q;
    data1_d = data1_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    err0_d  = 1'b0;
    err1_d  = 1'b0;
    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (arb_valid) begin
          id_d    = arb_grant;
          addr_d  = arb_grant ? rq1_addr : rq0_addr;
          re_d    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        re_d = 1'b1;
        if (wd_q != WD_MAX) begin
          wd_d = wd_q + 1'b1;
        end
        // A response arriving on the last allowed cycle still wins over abort
        if (mem_rd_ready) begin
          if (id_q) begin
            data1_d = mem_inst;
            ack1_d  = 1'b1;
          end else begin
            data0_d = mem_inst;
            ack0_d  = 1'b1;
          end
          re_d    = 1'b0;
          state_d = RELEASE;
        end else if ((TIMEOUT != 0) && (wd_q == TO_LAST)) begin
          err1_d  = id_q;
          err0_d  = ~id_q;
          re_d    = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        last_d  = id_q;
        wd_d    = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops read_enable immediately
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wd_q    <= '0;
      re_q    <= 1'b0;
      data0_q <= '0;
      data1_q <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      re_q    <= re_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
    end
  end

  assign mem_read_enable = re_q;
  assign mem_address     = addr_q;
  assign rq0_ack         = ack0_q;
  assign rq0_err         = err0_q;
  assign rq0_data        = data0_q;
  assign rq1_ack         = ack1_q;
  assign rq1_err         = err1_q;
  assign rq1_data        = data1_q;

endmodule : imem_read_arbiter
`default_nettype wire

// File: tb/tb_imem_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_read_arbiter
// Purpose  : Directed self-checking bench for imem_read_arbiter with a small
//            memory model whose response latency is set per scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_read_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rq0_req = 1'b0, rq1_req = 1'b0;
  logic [7:0]  rq0_addr = '0, rq1_addr = '0;
  logic        rq0_ack, rq0_err, rq1_ack, rq1_err;
  logic [15:0] rq0_data, rq1_data;
  logic        mem_read_enable;
  logic [7:0]  mem_address;
  logic        mem_rd_ready;
  logic [15:0] mem_inst;

  int          n_tests = 0;
  int          n_fail  = 0;

  // Memory model: responds on BUSY cycle number mem_lat (1 = hit); 0 = never
  int          mem_lat  = 1;
  logic [15:0] mem_data = '0;
  int          busy_cnt = 0;

  always #5 clock = ~clock;

  always @(posedge clock) busy_cnt <= mem_read_enable ? busy_cnt + 1 : 0;

  assign mem_rd_ready = mem_read_enable && (mem_lat != 0) && (busy_cnt == mem_lat - 1);
  assign mem_inst     = mem_data;

  imem_read_arbiter #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(8)) dut (
    .clock           (clock),
    .reset           (reset),
    .rq0_req         (rq0_req),
    .rq0_addr        (rq0_addr),
    .rq0_ack         (rq0_ack),
    .rq0_err         (rq0_err),
    .rq0_data        (rq0_data),
    .rq1_req         (rq1_req),
    .rq1_addr        (rq1_addr),
    .rq1_ack         (rq1_ack),
    .rq1_err         (rq1_err),
    .rq1_data        (rq1_data),
    .mem_read_enable (mem_read_enable),
    .mem_address     (mem_address),
    .mem_rd_ready    (mem_rd_ready),
    .mem_inst        (mem_inst)
  );

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wait_re(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_read_enable) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    mem_lat  = 1;
    mem_data = 16'h1111;
    reset    = 1'b0;
    rq0_req  = 1'b1;
    rq0_addr = 8'h02;
    tick(); tick(); tick();
    n_tests++;
    if ({mem_read_enable, rq0_ack, rq0_err, rq1_ack, rq1_err} !== 5'b0 ||
        rq0_data !== 16'h0 || rq1_data !== 16'h0 || mem_address !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: re=%b ack0=%b err0=%b ack1=%b err1=%b d0=%h d1=%h addr=%h, required all 0",
               mem_read_enable, rq0_ack, rq0_err, rq1_ack, rq1_err, rq0_data, rq1_data, mem_address);
    end
    reset = 1'b1;
    tick();
    n_tests++;
    if (mem_read_enable !== 1'b1 || mem_address !== 8'h02) begin
      n_fail++;
      $display("FAIL reset_release_busy: re=%b addr=%h, required re=1 addr=02", mem_read_enable, mem_address);
    end
    rq0_req = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_single_hit();
    mem_lat  = 1;
    mem_data = 16'hA5A5;
    rq0_req  = 1'b1;
    rq0_addr = 8'h02;
    tick();
    n_tests++;
    if (mem_read_enable !== 1'b1 || mem_address !== 8'h02 || rq0_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL hit_busy: re=%b addr=%h ack0=%b, required 1/02/0", mem_read_enable, mem_address, rq0_ack);
    end
    tick();
    n_tests++;
    if (rq0_ack !== 1'b1 || rq0_data !== 16'hA5A5 || mem_read_enable !== 1'b0 ||
        rq1_ack !== 1'b0 || rq0_err !== 1'b0) begin
      n_fail++;
      $display("FAIL hit_ack: ack0=%b d0=%h re=%b ack1=%b err0=%b, required 1/A5A5/0/0/0",
               rq0_ack, rq0_data, mem_read_enable, rq1_ack, rq0_err);
    end
    rq0_req = 1'b0;
    tick();
    n_tests++;
    if (rq0_ack !== 1'b0 || mem_read_enable !== 1'b0 || rq0_data !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL hit_pulse_once: ack0=%b re=%b d0=%h, required 0/0/A5A5", rq0_ack, mem_read_enable, rq0_data);
    end
    tick(); tick();
  endtask

  task automatic test_miss_latency();
    int bad = 0;
    mem_lat  = 6;
    mem_data = 16'h1234;
    rq0_req  = 1'b1;
    rq0_addr = 8'h03;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 2) rq0_addr = 8'hFF;
      if (mem_read_enable !== 1'b1 || mem_address !== 8'h03 || rq0_ack !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL miss_addr_stable: %0d bad BUSY cycles, required 0", bad);
    end
    tick();
    n_tests++;
    if (rq0_ack !== 1'b1 || rq0_data !== 16'h1234 || mem_read_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_ack: ack0=%b d0=%h re=%b, required 1/1234/0", rq0_ack, rq0_data, mem_read_enable);
    end
    rq0_req = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_contention();
    bit         ok;
    logic [7:0] exp_addr [3] = '{8'h01, 8'h05, 8'h01};
    bit         exp_port [3] = '{1'b0, 1'b1, 1'b0};
    do_reset();
    mem_lat  = 1;
    mem_data = 16'hBEEF;
    rq0_addr = 8'h01;
    rq1_addr = 8'h05;
    rq0_req  = 1'b1;
    rq1_req  = 1'b1;
    for (int g = 0; g < 3; g++) begin
      wait_re(ok);
      n_tests++;
      if (!ok || mem_address !== exp_addr[g]) begin
        n_fail++;
        $display("FAIL contention_grant%0d: re_seen=%0d addr=%h, required addr=%h", g, ok, mem_address, exp_addr[g]);
      end
      tick();
      n_tests++;
      if ({rq1_ack, rq0_ack} !== (exp_port[g] ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL contention_ack%0d: ack1ack0=%b%b, required port %0d only", g, rq1_ack, rq0_ack, exp_port[g]);
      end
    end
    rq0_req = 1'b0;
    rq1_req = 1'b0;
    n_tests++;
    if (rq0_data !== 16'hBEEF || rq1_data !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL contention_data: d0=%h d1=%h, required BEEF/BEEF", rq0_data, rq1_data);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_timeout();
    int bad = 0;
    mem_lat  = 0;
    mem_data = 16'hDEAD;
    rq1_req  = 1'b1;
    rq1_addr = 8'h07;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (mem_read_enable !== 1'b1 || rq1_err !== 1'b0 || rq1_ack !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL timeout_busy: %0d bad cycles in 8 BUSY cycles, required 0", bad);
    end
    tick();
    n_tests++;
    if (rq1_err !== 1'b1 || rq1_ack !== 1'b0 || rq1_data !== 16'hBEEF ||
        mem_read_enable !== 1'b0 || rq0_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_err: err1=%b ack1=%b d1=%h re=%b err0=%b, required 1/0/BEEF/0/0",
               rq1_err, rq1_ack, rq1_data, mem_read_enable, rq0_err);
    end
    rq1_req = 1'b0;
    tick();
    n_tests++;
    if (rq1_err !== 1'b0 || mem_read_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_pulse: err1=%b re=%b, required 0/0", rq1_err, mem_read_enable);
    end
    mem_lat  = 8;
    mem_data = 16'h0808;
    rq1_addr = 8'h08;
    rq1_req  = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    n_tests++;
    if (rq1_ack !== 1'b1 || rq1_err !== 1'b0 || rq1_data !== 16'h0808) begin
      n_fail++;
      $display("FAIL timeout_edge_ready: ack1=%b err1=%b d1=%h, required 1/0/0808", rq1_ack, rq1_err, rq1_data);
    end
    rq1_req = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid_busy();
    mem_lat  = 1;
    mem_data = 16'h4242;
    rq0_req  = 1'b1;
    rq0_addr = 8'h04;
    tick(); tick();
    rq0_req  = 1'b0;
    tick(); tick();
    mem_lat  = 0;
    rq1_req  = 1'b1;
    rq1_addr = 8'h09;
    tick(); tick(); tick();
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if (mem_read_enable !== 1'b0 || rq1_ack !== 1'b0 || rq1_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midbusy_reset_drop: re=%b ack1=%b err1=%b, required 0/0/0", mem_read_enable, rq1_ack, rq1_err);
    end
    tick();
    rq0_req  = 1'b1;
    rq0_addr = 8'h0A;
    mem_lat  = 1;
    reset    = 1'b1;
    tick();
    n_tests++;
    if (mem_read_enable !== 1'b1 || mem_address !== 8'h0A) begin
      n_fail++;
      $display("FAIL midbusy_port0_first: re=%b addr=%h, required 1/0A", mem_read_enable, mem_address);
    end
    tick();
    n_tests++;
    if (rq0_ack !== 1'b1 || rq1_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL midbusy_ack: ack0=%b ack1=%b, required 1/0", rq0_ack, rq1_ack);
    end
    rq0_req = 1'b0;
    rq1_req = 1'b0;
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_miss_latency();
    test_contention();
    test_timeout();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_imem_read_arbiter
`default_nettype wire
